mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multicycle control unit: the sequential successor to the single-cycle Control decoder.
- Drives a shared-memory multicycle datapath through a Moore FSM.
- Adds a memory ready/request handshake, bne, jal, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register opcode field and the datapath mux/enable controls.

Parameters:
- MEM_HANDSHAKE, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is ignored and treated as always 1.
- CNT_W, 16, width of the retired-instruction counter.
- HAS_JAL, 1, when 0 opcode 000011 is decoded as illegal.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Opcode  in  6  instruction register bits [31:26].
- Zero  in  1  ALU zero flag, valid in BRANCH state.
- mem_ready  in  1  memory has completed the current access.
- mem_req  out  1  memory access request.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write-register select: 1 = rd, 0 = rt.
- MemtoReg  out  1  write-data select: 1 = MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable.
- JALFlag  out  1  write PC+4 to $31.
- instr_done  out  1  one-cycle pulse on retire.
- illegal_op  out  1  sticky unsupported-opcode flag.
- instr_count  out  CNT_W  retired-instruction count.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = FETCH, illegal_op = 0, instr_count = 0.
  - While reset is asserted, all strobes (mem_req, MemRead, MemWrite, IRWrite, RegWrite, pc_en, instr_done) = 0.
  - Other outputs take the FETCH Moore values.
- Outputs are combinational from the state register only (Moore), except pc_en and the ready-gated strobes.
- Effective ready: rdy = mem_ready | ~MEM_HANDSHAKE.
- FETCH:
  - mem_req = 1, MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = rdy, pc_en = rdy.
  - Stays in FETCH while !rdy; goes to DECODE when rdy.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by Opcode:
  - 000000 -> EXEC
  - 100011 / 101011 -> MEMADR
  - 000100 / 000101 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - 000011 -> JAL (only if HAS_JAL)
  - anything else -> FETCH, set illegal_op, no retire.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD:
  - mem_req = 1, MemRead = 1, IorD = 1.
  - Waits until rdy, then goes to MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Retires, then FETCH.
- MEMWR:
  - mem_req = 1, MemWrite = rdy, IorD = 1.
  - Waits until rdy, then retires and goes to FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Goes to ALUWB.
- ALUWB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Retires, then FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSource = 01.
  - pc_en = (beq & Zero) | (bne & ~Zero).
  - Opcode is held stable by the datapath IR. Retires, then FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Retires, then FETCH.
- JUMP: PCSource = 10, pc_en = 1. Retires, then FETCH.
- JAL: PCSource = 10, pc_en = 1, RegWrite = 1, JALFlag = 1. Retires, then FETCH.
- Retire: instr_done = 1 for exactly the cycle of the final state; instr_count increments on that clock edge and wraps modulo 2^CNT_W.
- Latencies with zero wait states:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
  - j and jal: 3 cycles.
  - Each !rdy cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- illegal_op clears only on reset.
- Reset asserted mid-access (e.g. in MEMRD): mem_req drops asynchronously; no partial retire.
- mem_ready asserted outside a request state is ignored.

Decomposition:
- Shared package mips_pkg:
  - 4-bit state enumeration: FETCH = 0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JAL.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL.
  - ALUOp and PCSource encodings.
- One sub-module, mips_mc_outdec: pure combinational state-to-control-word decoder. The FSM, counter and flags stay in the parent.

Test Plan:
- Reset, then release with MEM_HANDSHAKE=0:
  - state_dbg = 0 (FETCH), instr_count = 0, illegal_op = 0.
  - First cycle: mem_req = 1, IRWrite = 1, pc_en = 1.
- R-type (Opcode = 000000), mem_ready tied 1:
  - States FETCH, DECODE, EXEC, ALUWB.
  - RegWrite = 1 and RegDst = 1 in cycle 4; instr_done pulses once; instr_count = 1.
- lw (100011), MEM_HANDSHAKE=1, mem_ready low 3 cycles in both FETCH and MEMRD:
  - Retire takes 11 cycles.
  - MemtoReg = 1 with RegWrite = 1 only in MEMWB.
- beq with Zero = 1, then bne with Zero = 1:
  - beq: pc_en = 1 in BRANCH.
  - bne: pc_en = 0 in BRANCH.
  - instr_count increments by 2.
- Opcode = 111111:
  - DECODE goes to FETCH; illegal_op = 1 and stays 1; instr_count unchanged; no RegWrite.
  - Repeat with HAS_JAL=0 and Opcode = 000011: same result.
- Reset pulled low while in MEMRD with mem_ready = 0:
  - mem_req = 0 immediately; state_dbg = 0.
  - After release, normal fetch resumes and instr_count = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       jal_flag;
  } ctl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// State-to-control-word decoder; only the ready-gated strobes and the
// branch PC enable look at anything besides the state.
module mips_mc_outdec
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       rdy,
  output ctl_t       ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.ir_write  = rdy;
        ctl.pc_en     = rdy;
      end
      DECODE: ctl.alu_src_b = SRCB_IMMSH;
      MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctl.mem_req  = 1'b1;
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctl.mem_req   = 1'b1;
        ctl.mem_write = rdy;
        ctl.iord      = 1'b1;
      end
      EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALUOP_SUB;
        ctl.pc_source = PCSRC_ALUOUT;
        ctl.pc_en     = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      ADDIWB: ctl.reg_write = 1'b1;
      JUMP: begin
        ctl.pc_source = PCSRC_JUMP;
        ctl.pc_en     = 1'b1;
      end
      JAL: begin
        ctl.pc_source = PCSRC_JUMP;
        ctl.pc_en     = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.jal_flag  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with memory handshake, retire counter and
// sticky illegal-opcode flag.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 16,
  parameter int HAS_JAL       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             pc_en,
  output logic             JALFlag,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  state_t state, state_nx;
  ctl_t   ctl;
  logic   rdy, retire, decode_bad;

  assign rdy = mem_ready | (MEM_HANDSHAKE == 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    decode_bad = 1'b0;
    case (state)
      FETCH:  if (rdy) state_nx = DECODE;
      DECODE: begin
        case (Opcode)
          OP_RTYPE:      state_nx = EXEC;
          OP_LW, OP_SW:  state_nx = MEMADR;
          OP_BEQ, OP_BNE: state_nx = BRANCH;
          OP_ADDI:       state_nx = ADDIEX;
          OP_J:          state_nx = JUMP;
          OP_JAL: begin
            if (HAS_JAL != 0) state_nx = JAL;
            else begin
              state_nx   = FETCH;
              decode_bad = 1'b1;
            end
          end
          default: begin
            state_nx   = FETCH;
            decode_bad = 1'b1;
          end
        endcase
      end
      MEMADR: state_nx = (Opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (rdy) state_nx = MEMWB;
      MEMWR:  if (rdy) state_nx = FETCH;
      EXEC:   state_nx = ALUWB;
      ADDIEX: state_nx = ADDIWB;
      default: state_nx = FETCH;
    endcase
  end

  mips_mc_outdec u_outdec (
    .state  (state),
    .opcode (Opcode),
    .zero   (Zero),
    .rdy    (rdy),
    .ctl    (ctl)
  );

  // A store retires on the cycle its write is accepted, not while it waits.
  always_comb begin
    retire = 1'b0;
    case (state)
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, JAL: retire = 1'b1;
      MEMWR:   retire = rdy;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == DECODE && decode_bad) illegal_op <= 1'b1;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Strobes are forced low for as long as reset is held, independent of the clock.
  assign mem_req    = ctl.mem_req   & reset;
  assign MemRead    = ctl.mem_read  & reset;
  assign MemWrite   = ctl.mem_write & reset;
  assign IRWrite    = ctl.ir_write  & reset;
  assign RegWrite   = ctl.reg_write & reset;
  assign pc_en      = ctl.pc_en     & reset;
  assign instr_done = retire        & reset;

  assign IorD      = ctl.iord;
  assign RegDst    = ctl.reg_dst;
  assign MemtoReg  = ctl.mem_to_reg;
  assign ALUSrcA   = ctl.alu_src_a;
  assign ALUSrcB   = ctl.alu_src_b;
  assign ALUOp     = ctl.alu_op;
  assign PCSource  = ctl.pc_source;
  assign JALFlag   = ctl.jal_flag;
  assign state_dbg = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench: two control units (handshake+jal, and no-handshake/no-jal
// with a 4-bit counter) checked cycle by cycle against an instruction-level model.
module tb_mips_mc_control;

  localparam int S_F = 0, S_D = 1, S_MADR = 2, S_MRD = 3, S_MWB = 4, S_MWR = 5,
                 S_EX = 6, S_AWB = 7, S_BR = 8, S_AIEX = 9, S_AIWB = 10, S_J = 11, S_JAL = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, z_a, z_b, rdy_a, rdy_b;
  logic [5:0] op_a, op_b;

  logic a_mem_req, a_IorD, a_MemRead, a_MemWrite, a_IRWrite, a_RegDst, a_MemtoReg, a_RegWrite;
  logic a_ALUSrcA, a_pc_en, a_JALFlag, a_instr_done, a_illegal_op;
  logic [1:0] a_ALUSrcB, a_ALUOp, a_PCSource;
  logic [15:0] a_cnt;
  logic [3:0] a_state;

  logic b_mem_req, b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_RegDst, b_MemtoReg, b_RegWrite;
  logic b_ALUSrcA, b_pc_en, b_JALFlag, b_instr_done, b_illegal_op;
  logic [1:0] b_ALUSrcB, b_ALUOp, b_PCSource;
  logic [3:0] b_cnt;
  logic [3:0] b_state;

  mips_mc_control #(.MEM_HANDSHAKE(1), .CNT_W(16), .HAS_JAL(1)) dut_a (
    .clk(clk), .reset(rst_a), .Opcode(op_a), .Zero(z_a), .mem_ready(rdy_a),
    .mem_req(a_mem_req), .IorD(a_IorD), .MemRead(a_MemRead), .MemWrite(a_MemWrite),
    .IRWrite(a_IRWrite), .RegDst(a_RegDst), .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite),
    .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .PCSource(a_PCSource),
    .pc_en(a_pc_en), .JALFlag(a_JALFlag), .instr_done(a_instr_done),
    .illegal_op(a_illegal_op), .instr_count(a_cnt), .state_dbg(a_state)
  );

  mips_mc_control #(.MEM_HANDSHAKE(0), .CNT_W(4), .HAS_JAL(0)) dut_b (
    .clk(clk), .reset(rst_b), .Opcode(op_b), .Zero(z_b), .mem_ready(rdy_b),
    .mem_req(b_mem_req), .IorD(b_IorD), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .IRWrite(b_IRWrite), .RegDst(b_RegDst), .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite),
    .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .PCSource(b_PCSource),
    .pc_en(b_pc_en), .JALFlag(b_JALFlag), .instr_done(b_instr_done),
    .illegal_op(b_illegal_op), .instr_count(b_cnt), .state_dbg(b_state)
  );

  logic [16:0] ctl_a, ctl_b;
  assign ctl_a = {a_mem_req, a_IorD, a_MemRead, a_MemWrite, a_IRWrite, a_RegDst, a_MemtoReg,
                  a_RegWrite, a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_PCSource, a_pc_en, a_JALFlag};
  assign ctl_b = {b_mem_req, b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_RegDst, b_MemtoReg,
                  b_RegWrite, b_ALUSrcA, b_ALUSrcB, b_ALUOp, b_PCSource, b_pc_en, b_JALFlag};

  int n_chk  = 0;
  int n_pass = 0;
  int cnt_m[2];
  bit ill_m[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Control word each state should present, straight from the state table.
  function automatic logic [16:0] exp_ctl(int st, logic [5:0] op, logic z, logic r, logic rn);
    logic mreq = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0;
    logic asa = 0, pce = 0, jf = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0;
    case (st)
      S_F:    begin mreq = 1; mrd = 1; asb = 2'b01; irw = r; pce = r; end
      S_D:    asb = 2'b11;
      S_MADR: begin asa = 1; asb = 2'b10; end
      S_MRD:  begin mreq = 1; mrd = 1; iord = 1; end
      S_MWB:  begin rw = 1; m2r = 1; end
      S_MWR:  begin mreq = 1; mwr = r; iord = 1; end
      S_EX:   begin asa = 1; aop = 2'b10; end
      S_AWB:  begin rw = 1; rdst = 1; end
      S_BR:   begin asa = 1; aop = 2'b01; pcs = 2'b01;
                    pce = (op == 6'b000100 && z) || (op == 6'b000101 && !z); end
      S_AIEX: begin asa = 1; asb = 2'b10; end
      S_AIWB: rw = 1;
      S_J:    begin pcs = 2'b10; pce = 1; end
      S_JAL:  begin pcs = 2'b10; pce = 1; rw = 1; jf = 1; end
      default: ;
    endcase
    if (!rn) begin mreq = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; pce = 0; end
    return {mreq, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, pce, jf};
  endfunction

  // Runs one instruction on dut_a (sel=0) or dut_b (sel=1). waits<0 gives random
  // ready; otherwise ready stays low for 'waits' cycles in every waiting state.
  task automatic run_instr(input int sel, input logic [5:0] op, input logic z,
                           input int waits, output int cycles);
    int  q[$];
    bit  legal = 1;
    int  idx = 0, wcnt = 0, st;
    bit  r, r_eff, wait_st, adv, last, done_e;
    case (op)
      6'b000000: q = '{S_F, S_D, S_EX, S_AWB};
      6'b100011: q = '{S_F, S_D, S_MADR, S_MRD, S_MWB};
      6'b101011: q = '{S_F, S_D, S_MADR, S_MWR};
      6'b000100, 6'b000101: q = '{S_F, S_D, S_BR};
      6'b001000: q = '{S_F, S_D, S_AIEX, S_AIWB};
      6'b000010: q = '{S_F, S_D, S_J};
      6'b000011: if (sel == 0) q = '{S_F, S_D, S_JAL};
                 else begin q = '{S_F, S_D}; legal = 0; end
      default:   begin q = '{S_F, S_D}; legal = 0; end
    endcase
    cycles = 0;
    while (idx < q.size() && cycles < 100) begin
      @(negedge clk);
      r = (waits < 0) ? ($urandom_range(0, 3) != 0) : (wcnt >= waits);
      if (sel == 0) begin op_a = op; z_a = z; rdy_a = r; end
      else          begin op_b = op; z_b = z; rdy_b = r; end
      r_eff = (sel == 0) ? r : 1'b1;
      #1;
      st      = q[idx];
      wait_st = (st == S_F) || (st == S_MRD) || (st == S_MWR);
      adv     = !wait_st || r_eff;
      last    = (idx == q.size() - 1);
      done_e  = last && legal && adv;
      if (sel == 0) begin
        chk("a_state", a_state, st);
        chk("a_ctl", ctl_a, exp_ctl(st, op, z, r_eff, 1'b1));
        chk("a_done", a_instr_done, done_e);
        chk("a_count", a_cnt, cnt_m[0]);
        chk("a_illegal", a_illegal_op, ill_m[0]);
      end else begin
        chk("b_state", b_state, st);
        chk("b_ctl", ctl_b, exp_ctl(st, op, z, r_eff, 1'b1));
        chk("b_done", b_instr_done, done_e);
        chk("b_count", b_cnt, cnt_m[1]);
        chk("b_illegal", b_illegal_op, ill_m[1]);
      end
      @(posedge clk);
      cycles++;
      if (done_e) cnt_m[sel] = (cnt_m[sel] + 1) % ((sel == 0) ? 65536 : 16);
      if (last && !legal && adv) ill_m[sel] = 1;
      if (adv) begin idx++; wcnt = 0; end
      else wcnt++;
    end
    if (idx != q.size()) chk("cycle_budget", idx, q.size());
  endtask

  logic [5:0] ops [8];
  int cyc;

  initial begin
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b000101; ops[5] = 6'b001000; ops[6] = 6'b000010; ops[7] = 6'b000011;
    rst_a = 0; rst_b = 0; op_a = 0; op_b = 0; z_a = 0; z_b = 0; rdy_a = 0; rdy_b = 0;
    cnt_m[0] = 0; cnt_m[1] = 0; ill_m[0] = 0; ill_m[1] = 0;

    repeat (2) @(negedge clk);
    rdy_a = 1; rdy_b = 1;
    #1;
    chk("rst_a_state", a_state, S_F);
    chk("rst_a_ctl", ctl_a, exp_ctl(S_F, 6'd0, 1'b0, 1'b1, 1'b0));
    chk("rst_a_done", a_instr_done, 1'b0);
    chk("rst_b_state", b_state, S_F);
    chk("rst_b_ctl", ctl_b, exp_ctl(S_F, 6'd0, 1'b0, 1'b1, 1'b0));
    chk("rst_b_count", b_cnt, 0);
    chk("rst_b_illegal", b_illegal_op, 1'b0);

    // No-handshake, no-jal unit; counter is 4 bits so it wraps within the loop.
    @(posedge clk); #2 rst_b = 1;
    run_instr(1, 6'b000000, 1'b0, -1, cyc);
    chk("b_rtype_cycles", cyc, 4);
    run_instr(1, 6'b111111, 1'b0, -1, cyc);
    run_instr(1, 6'b000011, 1'b0, -1, cyc);
    chk("b_jal_illegal_cycles", cyc, 2);
    for (int i = 0; i < 20; i++)
      run_instr(1, ops[$urandom_range(0, 7)], 1'(($urandom_range(0, 1))), -1, cyc);

    @(negedge clk); rst_b = 0; cnt_m[1] = 0; ill_m[1] = 0;
    @(posedge clk); #2 rst_a = 1;
    run_instr(0, 6'b000000, 1'b0, 0, cyc);  chk("rtype_cycles", cyc, 4);
    run_instr(0, 6'b100011, 1'b0, 3, cyc);  chk("lw_wait_cycles", cyc, 11);
    run_instr(0, 6'b100011, 1'b0, 0, cyc);  chk("lw_cycles", cyc, 5);
    run_instr(0, 6'b101011, 1'b0, 0, cyc);  chk("sw_cycles", cyc, 4);
    run_instr(0, 6'b000100, 1'b1, 0, cyc);  chk("beq_cycles", cyc, 3);
    run_instr(0, 6'b000101, 1'b1, 0, cyc);
    run_instr(0, 6'b001000, 1'b0, 0, cyc);  chk("addi_cycles", cyc, 4);
    run_instr(0, 6'b000010, 1'b0, 0, cyc);  chk("j_cycles", cyc, 3);
    run_instr(0, 6'b000011, 1'b0, 0, cyc);  chk("jal_cycles", cyc, 3);
    run_instr(0, 6'b111111, 1'b0, 0, cyc);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0)
        run_instr(0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), -1, cyc);
      else
        run_instr(0, ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), -1, cyc);
    end

    // Reset dropped while a load waits on memory.
    @(negedge clk); op_a = 6'b100011; rdy_a = 1;
    @(negedge clk); rdy_a = 0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("abort_pre_state", a_state, S_MRD);
    chk("abort_pre_req", a_mem_req, 1'b1);
    #2 rst_a = 0;
    #1;
    chk("abort_req", a_mem_req, 1'b0);
    chk("abort_state", a_state, S_F);
    chk("abort_count", a_cnt, 0);
    chk("abort_illegal", a_illegal_op, 1'b0);
    cnt_m[0] = 0; ill_m[0] = 0;
    @(posedge clk); #2 rst_a = 1;
    run_instr(0, 6'b000000, 1'b0, 1, cyc);
    run_instr(0, 6'b101011, 1'b0, 2, cyc);  chk("sw_wait_cycles", cyc, 8);
    @(negedge clk); #1;
    chk("final_count", a_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
